// File: rtl/dimmer_duty_gen.sv
// Duty-cycle sequencer for the LED dimmer PWM core: steps a waveform phase on a
// clock-enable tick and commits the resulting duty only at PWM period boundaries.
module dimmer_duty_gen #(
    parameter int          R       = 8,
    parameter logic [31:0] DEF_DIV = 32'd2499999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic         div_we,
    input  logic [31:0]  div_in,
    input  logic         period_start,
    output logic [R:0]   duty,
    output logic         duty_update,
    output logic [R-1:0] phase
);

    logic [31:0] div;
    logic [31:0] cnt;
    logic [1:0]  mode_q;
    logic [R:0]  shadow;
    logic [R:0]  target;
    logic        mode_chg;
    logic        tick;
    logic [6:0]  sin_idx;
    logic [6:0]  sin_val;

    // Quarter-wave table: round(127 * sin(pi * i / 128)), i = 0..64.
    function automatic logic [6:0] qsin(input logic [6:0] i);
        logic [6:0] q;
        case (i)
            7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
            7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
            7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
            7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
            7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
            7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
            7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
            7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
            7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
            7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
            7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
            7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
            7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
            7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
            7'd64: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    assign mode_chg = (mode != mode_q);
    assign tick     = enable && !div_we && !mode_chg && (cnt == div);

    // Odd quadrants walk the table backwards; upper half mirrors below mid-scale.
    assign sin_idx = phase[6] ? (7'd64 - {1'b0, phase[5:0]}) : {1'b0, phase[5:0]};
    assign sin_val = qsin(sin_idx);

    always_comb begin
        target = '0;
        case (mode_q)
            2'b00: target = '0;
            2'b01: target = {1'b0, phase};
            // 2*(256-p) equals -(2p) modulo 512, so the falling edge is a negate.
            2'b10: target = phase[7] ? (9'd0 - {phase, 1'b0}) : {phase, 1'b0};
            2'b11: target = phase[7] ? (9'd128 - {2'b00, sin_val})
                                     : (9'd128 + {2'b00, sin_val});
            default: target = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            div    <= DEF_DIV;
            mode_q <= 2'b00;
            phase  <= '0;
        end else begin
            if (mode_chg) begin
                mode_q <= mode;
                phase  <= '0;
                cnt    <= '0;
            end else begin
                if (tick) begin
                    phase <= phase + 8'd1;
                end
                if (div_we) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= (cnt == div) ? 32'd0 : cnt + 32'd1;
                end
            end
            if (div_we) begin
                div <= div_in;
            end
        end
    end

    // Shadow samples the target every cycle; duty only moves on a period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            duty        <= '0;
            duty_update <= 1'b0;
        end else begin
            shadow <= target;
            if (period_start) begin
                duty        <= shadow;
                duty_update <= (shadow != duty);
            end else begin
                duty_update <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dimmer_duty_gen.sv
// Directed bench for dimmer_duty_gen: sawtooth, triangle, sine, commit gating,
// enable freeze, mode switch and reset recovery.
module tb_dimmer_duty_gen;

    localparam int TB_DEF_DIV = 300;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic        div_we;
    logic [31:0] div_in;
    logic        period_start;
    logic [8:0]  duty;
    logic        duty_update;
    logic [7:0]  phase;

    int n_checks = 0;
    int n_errors = 0;

    dimmer_duty_gen #(.R(8), .DEF_DIV(TB_DEF_DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .div_we(div_we),
        .div_in(div_in), .period_start(period_start), .duty(duty),
        .duty_update(duty_update), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tri_val(input int p);
        return (p < 128) ? 2 * p : 2 * (256 - p);
    endfunction

    task automatic do_reset(input logic [1:0] m, input int d);
        rst = 1'b1; mode = m; enable = 1'b0; period_start = 1'b0;
        div_we = 1'b0; div_in = 32'd0;
        step();
        step();
        check("rst_duty", duty, 0);
        check("rst_upd", duty_update, 0);
        check("rst_phase", phase, 0);
        rst = 1'b0;
        step();
        div_we = 1'b1; div_in = d;
        step();
        div_we = 1'b0;
        check("setup_phase", phase, 0);
    endtask

    task automatic go_to_phase(input int p);
        int n = 0;
        enable = 1'b1;
        while (int'(phase) != p && n < 600) begin
            step();
            n++;
        end
        enable = 1'b0;
        check("reach_phase", phase, p);
    endtask

    initial begin
        int last, n_upd, since_tick, prev_phase, k, exp_v, seen_peak, first_tick;
        logic [7:0] exp_phase;
        int commit_exp;
        int sin_ph[8]  = '{0, 16, 32, 64, 96, 128, 192, 224};
        int sin_exp[8] = '{128, 177, 218, 255, 218, 128, 1, 38};

        // Sawtooth, divider 3: tick every 4 clk, duty 1..255 then wraps to 0.
        do_reset(2'b01, 3);
        enable = 1'b1; period_start = 1'b1;
        last = 0; n_upd = 0; since_tick = 0; prev_phase = 0;
        for (int i = 0; i < 1200 && n_upd < 256; i++) begin
            step();
            since_tick++;
            if (int'(phase) != prev_phase) begin
                check("saw_tick_gap", since_tick, 4);
                check("saw_phase_inc", phase, (prev_phase + 1) & 255);
                since_tick = 0;
                prev_phase = phase;
            end
            if (duty_update) begin
                check("saw_duty", duty, (last + 1) & 255);
                last = (last + 1) & 255;
                n_upd++;
            end else begin
                check("saw_hold", duty, last);
            end
        end
        check("saw_updates", n_upd, 256);
        check("saw_wrap_zero", duty, 0);

        // Triangle, divider 0: 0,2,..,254,256,254,..,2,0.
        do_reset(2'b10, 0);
        enable = 1'b1; period_start = 1'b1;
        last = 0; k = 0; n_upd = 0; seen_peak = 0;
        for (int i = 0; i < 262; i++) begin
            step();
            if (duty == 9'd256) seen_peak = 1;
            if (duty_update) begin
                k = (k + 1) & 255;
                exp_v = tri_val(k);
                check("tri_duty", duty, exp_v);
                last = exp_v;
                n_upd++;
            end else begin
                check("tri_hold", duty, last);
            end
        end
        check("tri_updates", n_upd, 260);
        check("tri_peak_seen", seen_peak, 1);

        // Sine at selected phases, phase frozen with enable=0 before each commit.
        do_reset(2'b11, 0);
        for (int i = 0; i < 8; i++) begin
            go_to_phase(sin_ph[i]);
            step();
            step();
            period_start = 1'b1;
            step();
            period_start = 1'b0;
            check($sformatf("sin_duty_p%0d", sin_ph[i]), duty, sin_exp[i]);
            check($sformatf("sin_upd_p%0d", sin_ph[i]), duty_update, 1);
        end

        // Sawtooth, tick every clk, commit every 10 clk: duty only moves after a commit.
        do_reset(2'b01, 0);
        enable = 1'b1;
        exp_phase = 8'd0; last = 0;
        for (int i = 0; i < 300; i++) begin
            period_start = (i % 10 == 9);
            commit_exp = (int'(exp_phase) + 255) & 255;
            step();
            exp_phase = exp_phase + 8'd1;
            check("gate_phase", phase, exp_phase);
            if (period_start) begin
                check("gate_commit", duty, commit_exp);
                check("gate_upd", duty_update, 1);
                last = commit_exp;
            end else begin
                check("gate_hold", duty, last);
                check("gate_no_upd", duty_update, 0);
            end
        end

        // Freeze at phase 100 for 50 clk with commits running, then switch to sine.
        period_start = 1'b1;
        go_to_phase(100);
        for (int i = 1; i <= 50; i++) begin
            step();
            check("frz_phase", phase, 100);
            if (i >= 2) check("frz_duty", duty, 100);
        end
        period_start = 1'b0;
        mode = 2'b11;
        step();
        check("mchg_phase", phase, 0);
        step();
        step();
        check("mchg_no_commit", duty, 100);
        period_start = 1'b1;
        step();
        period_start = 1'b0;
        check("mchg_duty", duty, 128);
        check("mchg_upd", duty_update, 1);
        check("mchg_phase_held", phase, 0);

        // Reset while duty=200: immediate clear, then first tick after TB_DEF_DIV+1 clk.
        do_reset(2'b01, 0);
        go_to_phase(200);
        step();
        period_start = 1'b1;
        step();
        period_start = 1'b0;
        check("pre_rst_duty", duty, 200);
        rst = 1'b1; mode = 2'b00; enable = 1'b1;
        step();
        check("mid_rst_duty", duty, 0);
        check("mid_rst_phase", phase, 0);
        check("mid_rst_upd", duty_update, 0);
        rst = 1'b0;
        first_tick = 0;
        for (int i = 1; i <= TB_DEF_DIV + 10 && first_tick == 0; i++) begin
            step();
            if (phase != 8'd0) first_tick = i;
        end
        check("def_div_first_tick", first_tick, TB_DEF_DIV + 1);
        check("post_rst_duty", duty, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
